my_sync_fifo_rdvar: RTL
=======================

// Module: my_sync_fifo_rdvar
// PURPOSE
//  Read-side counterpart of the bilinear path's 1/2/3-sample writer FIFO: accepts a fixed
//  2 samples per write and lets the consumer pop 0..3 samples per cycle. This matches the
//  scaling phase of the bilinear upscaler. The read window is always the 3 oldest samples.
//  It sits between the 2-pixel/clk line fetch and the variable-step interpolation core.
// PARAMETERS
//  DW          8          bits per sample
//  FIFO_DEPTH  16         storage in samples; power of two, >= 4
//  ADDR_WIDTH  $clog2(FIFO_DEPTH)  localparam, pointer width
// PORTS
//  clk       in   1               rising-edge clock, sole clock domain
//  rst_n     in   1               synchronous active-low reset
//  flush     in   1               sync discard of all contents (frame start)
//  wr_en     in   1               push request, 2 samples
//  wr_data   in   2*DW            [2DW-1:DW] older sample, [DW-1:0] newer sample
//  wr_ready  out  1               room for 2 samples this cycle
//  rd_num    in   2               samples to pop this cycle (0..3)
//  rd_data   out  3*DW            peek window: [3DW-1:2DW] oldest, [DW-1:0] third-oldest
//  rd_level  out  ADDR_WIDTH+1    current sample count
//  full      out  1               rd_level == FIFO_DEPTH
//  empty     out  1               rd_level == 0
//  wr_ovf    out  1               1-cycle pulse: write rejected
//  rd_unf    out  1               1-cycle pulse: pop rejected
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_ptr, rd_ptr and count = 0. All memory entries = 0.
//    wr_ovf and rd_unf = 0. After reset: empty=1, full=0, wr_ready=1, rd_data=0.
//  - Reset mid-operation discards all data. Reset has priority over flush, wr and rd.
//  - flush: same as reset for pointers, count and flags. Memory is not cleared.
//    flush has priority over wr/rd in the same cycle, so a coincident push and pop are
//    both dropped. No ovf/unf pulse is raised.
//  - wr_ready = (count <= FIFO_DEPTH-2). It is a function of the registered count only.
//    A same-cycle pop does not grant room.
//  - wr_acc = wr_en & wr_ready. On wr_acc: mem[wr_ptr] <= wr_data[2DW-1:DW] and
//    mem[wr_ptr+1] <= wr_data[DW-1:0]; wr_ptr += 2.
//  - wr_en & !wr_ready: no write, pointers hold, wr_ovf=1 on the next cycle.
//  - pop = (rd_num <= count) ? rd_num : 0. The check uses the registered count; samples
//    written this cycle are not poppable. rd_ptr += pop.
//  - rd_num > count: nothing pops, rd_unf=1 on the next cycle. There is no partial pop.
//  - count_next = count + 2*wr_acc - pop. Simultaneous push and pop are always legal.
//    The count never exceeds FIFO_DEPTH and never goes below 0.
//  - Pointers wrap modulo FIFO_DEPTH, including rd_ptr+1 and +2 in the peek and
//    wr_ptr+1 in the write.
//  - rd_data is combinational from rd_ptr: {mem[rd_ptr], mem[rd_ptr+1], mem[rd_ptr+2]}.
//    Latency is 0 from the pointer update. Written data is visible the cycle after wr_acc.
//    Slots at index >= count are stale, and the consumer must use rd_level to qualify them.
//  - rd_level, full and empty are derived combinationally from the registered count.
//  - rd_num is ignored while rst_n=0 or flush=1.
// TESTING  (DW=8, FIFO_DEPTH=8)
//  1. Reset, then push 0xA1A2, 0xA3A4 -> rd_level=4, rd_data=0xA1A2A3. Then rd_num=3
//     -> next cycle rd_level=1, rd_data[23:16]=0xA4.
//  2. Fill with 4 pushes -> full=1, wr_ready=0. A 5th push -> no change, wr_ovf pulses
//     once, rd_level=8.
//  3. Set count=1, push 0xB1B2 and rd_num=1 in the same cycle -> rd_level=2,
//     rd_data[23:8]=0xB1B2.
//  4. Set count=2, rd_num=3 -> no pop, rd_unf=1 the next cycle, rd_level=2, rd_data unchanged.
//  5. Run 20 cycles alternating push and pop (rd_num 1,2,3 cycling) so the pointers wrap
//     -> the popped stream equals the pushed stream in order, with no ovf/unf.
//  6. At count=6, flush with wr_en=1 -> rd_level=0, empty=1, no flags. Assert rst_n=0
//     mid-stream -> all outputs return to their reset values.

Source files
------------

// File: rtl/my_sync_fifo_rdvar.sv
// Sync FIFO with a fixed 2-sample write and a 0..3-sample variable pop.
// The read side always sees a combinational peek window of the 3 oldest slots.
module my_sync_fifo_rdvar #(
    parameter int unsigned DW         = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [2*DW-1:0]               wr_data,
    output logic                          wr_ready,
    input  logic [1:0]                    rd_num,
    output logic [3*DW-1:0]               rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   rd_level,
    output logic                          full,
    output logic                          empty,
    output logic                          wr_ovf,
    output logic                          rd_unf
);

    localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = ADDR_WIDTH + 1;

    logic [DW-1:0]         mem_q [FIFO_DEPTH];
    logic [DW-1:0]         mem_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ovf_q, wr_ovf_d;
    logic                  rd_unf_q, rd_unf_d;

    logic                  wr_acc;
    logic                  pop_ok;
    logic [CW-1:0]         pop;
    logic [ADDR_WIDTH-1:0] wr_ptr_p1;
    logic [ADDR_WIDTH-1:0] rd_ptr_p1;
    logic [ADDR_WIDTH-1:0] rd_ptr_p2;

    // Room is judged on the registered count only; a same-cycle pop grants nothing.
    assign wr_ready  = (count_q <= CW'(FIFO_DEPTH - 2));
    assign wr_acc    = wr_en & wr_ready;
    assign pop_ok    = (CW'(rd_num) <= count_q);
    assign pop       = pop_ok ? CW'(rd_num) : '0;

    // ADDR_WIDTH-wide sums wrap modulo FIFO_DEPTH on their own.
    assign wr_ptr_p1 = wr_ptr_q + ADDR_WIDTH'(1);
    assign rd_ptr_p1 = rd_ptr_q + ADDR_WIDTH'(1);
    assign rd_ptr_p2 = rd_ptr_q + ADDR_WIDTH'(2);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_ovf_d = 1'b0;
        rd_unf_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                mem_d[wr_ptr_q]  = wr_data[2*DW-1:DW];
                mem_d[wr_ptr_p1] = wr_data[DW-1:0];
                wr_ptr_d         = wr_ptr_q + ADDR_WIDTH'(2);
            end
            rd_ptr_d = rd_ptr_q + pop[ADDR_WIDTH-1:0];
            count_d  = count_q + (wr_acc ? CW'(2) : CW'(0)) - pop;
            wr_ovf_d = wr_en & ~wr_ready;
            rd_unf_d = ~pop_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ovf_q <= 1'b0;
            rd_unf_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_ovf_q <= wr_ovf_d;
            rd_unf_q <= rd_unf_d;
        end
    end

    assign rd_data  = {mem_q[rd_ptr_q], mem_q[rd_ptr_p1], mem_q[rd_ptr_p2]};
    assign rd_level = count_q;
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ovf   = wr_ovf_q;
    assign rd_unf   = rd_unf_q;

endmodule
